// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM state encoding,
// prefix byte values and the bit layout of a key event.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    localparam int EV_W        = 10;
    localparam int EV_XPD      = 9;
    localparam int EV_RLS      = 8;
    localparam int EV_CODE_MSB = 7;
    localparam int EV_CODE_LSB = 0;

    // Odd parity over code+parity, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] code, input logic par,
                                      input logic stop);
        return (^{code, par}) & stop;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: event FIFO read port and status flags.
// master = consumer (game FSM / VGA logic), slave = receiver.
interface ps2_keyboard_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            rd_en;
    logic            clr_err;
    logic [EV_W-1:0] rd_data;
    logic            empty;
    logic            full;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            frame_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, empty, full, count, overflow, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, empty, full, count, overflow, frame_err
    );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO with count and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_rd_en,
    input  logic                       i_clr_ovf,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_push && (!w_full || w_do_rd);

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear must stay visible.
            if (i_push && w_full && !i_rd_en) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: pin sync + glitch filter, 11-bit frame FSM, E0/F0 prefix folding,
// event FIFO. Optional mid-frame timeout abort enabled by defining PS2_RX_TIMEOUT_EN.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 on a strobe)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking stop bit and parity, then folding/pushing the code
module ps2_keyboard_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ps2k_clk,
    input  logic                   i_ps2k_data,
    ps2_keyboard_rx_fifo_if.slave  bus
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    logic r_clk_s1, r_clk_s2;
    logic r_dat_s1, r_dat_s2;

    logic [FLT_W-1:0] r_flt_cnt;
    logic             r_flt_clk;
    logic             r_flt_d;
    logic             r_strobe;
    logic             w_fall;

    ps2_state_e       r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic             r_parity;
    logic             r_pend_xpd;
    logic             r_pend_rls;
    logic             r_push;
    logic [EV_W-1:0]  r_push_data;
    logic             r_frame_err;
    logic             w_timeout;

    logic [EV_W-1:0]  w_rd_data;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count;
    logic             w_overflow;

    // Both pins idle high, so the synchronisers come out of reset at 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2k_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2k_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Down-counter of samples disagreeing with the filtered clock; terminal count flips it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flt_cnt <= FLT_W'(FILTER_LEN - 1);
            r_flt_clk <= 1'b1;
            r_flt_d   <= 1'b1;
            r_strobe  <= 1'b0;
        end else begin
            r_flt_d  <= r_flt_clk;
            r_strobe <= w_fall;
            if (r_clk_s2 == r_flt_clk) begin
                r_flt_cnt <= FLT_W'(FILTER_LEN - 1);
            end else if (r_flt_cnt == '0) begin
                r_flt_clk <= r_clk_s2;
                r_flt_cnt <= FLT_W'(FILTER_LEN - 1);
            end else begin
                r_flt_cnt <= r_flt_cnt - 1'b1;
            end
        end
    end

    assign w_fall = r_flt_d && !r_flt_clk;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || r_strobe) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (r_state != ST_IDLE && r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == '0) && !r_strobe;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_pend_xpd  <= 1'b0;
            r_pend_rls  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            // Any error set below in this cycle overrides the clear.
            if (bus.clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
                r_pend_xpd  <= 1'b0;
                r_pend_rls  <= 1'b0;
            end else if (r_strobe) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd7;
                        end
                    end
                    ST_DATA: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        if (r_bit_cnt == '0) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (frame_ok(r_shift, r_parity, r_dat_s2)) begin
                            if (r_shift == PS2_PREFIX_EXT) begin
                                r_pend_xpd <= 1'b1;
                            end else if (r_shift == PS2_PREFIX_REL) begin
                                r_pend_rls <= 1'b1;
                            end else begin
                                r_push                                <= 1'b1;
                                r_push_data[EV_XPD]                   <= r_pend_xpd;
                                r_push_data[EV_RLS]                   <= r_pend_rls;
                                r_push_data[EV_CODE_MSB:EV_CODE_LSB]  <= r_shift;
                                r_pend_xpd                            <= 1'b0;
                                r_pend_rls                            <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_pend_xpd  <= 1'b0;
                            r_pend_rls  <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (r_push),
        .i_wdata    (r_push_data),
        .i_rd_en    (bus.rd_en),
        .i_clr_ovf  (bus.clr_err),
        .o_rdata    (w_rd_data),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    assign bus.rd_data   = w_rd_data;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = w_count;
    assign bus.overflow  = w_overflow;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Directed bench for ps2_keyboard_rx_fifo: bit-banged PS/2 frames, hand-computed events.
// The timeout scenario is exercised only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_keyboard_rx_fifo;
    localparam int FILTER_LEN     = 4;
    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 40;

    logic clk = 1'b0;
    logic rst;
    logic ps2c;
    logic ps2d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ps2_keyboard_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    ps2_keyboard_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2k_clk  (ps2c),
        .i_ps2k_data (ps2d),
        .bus         (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, then a low half-period.
    // glitch: 2-cycle low pulse in the high phase. pop_at_push: rd_en on the push cycle.
    task automatic ps2_bit(input logic b, input bit glitch, input bit pop_at_push);
        ps2d = b;
        if (glitch) begin
            tick(10);
            ps2c = 1'b0;
            tick(2);
            ps2c = 1'b1;
            tick(HALF - 12);
        end else begin
            tick(HALF);
        end
        ps2c = 1'b0;
        if (pop_at_push) begin
            tick(8);
            bus.rd_en = 1'b1;
            tick(1);
            bus.rd_en = 1'b0;
            tick(HALF - 9);
        end else begin
            tick(HALF);
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit glitch,
                              input bit pop_at_push);
        logic par;
        par = (~^code) ^ bad_par;
        ps2_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch, 1'b0);
        ps2_bit(par, glitch, 1'b0);
        ps2_bit(1'b1, glitch, pop_at_push);
        ps2d = 1'b1;
        tick(20);
    endtask

    task automatic frame(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;
        rst         = 1'b1;
        ps2c        = 1'b1;
        ps2d        = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(1);

        check_val("rst_empty", 32'(bus.empty), 32'h1);
        check_val("rst_full", 32'(bus.full), 32'h0);
        check_val("rst_count", 32'(bus.count), 32'h0);
        check_val("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check_val("rst_overflow", 32'(bus.overflow), 32'h0);
        check_val("rst_frame_err", 32'(bus.frame_err), 32'h0);

        frame(8'h1C);
        check_val("f1c_empty", 32'(bus.empty), 32'h0);
        check_val("f1c_count", 32'(bus.count), 32'h1);
        check_val("f1c_data", 32'(bus.rd_data), 32'h01C);
        check_val("f1c_ferr", 32'(bus.frame_err), 32'h0);
        pop();
        check_val("f1c_pop_empty", 32'(bus.empty), 32'h1);

        frame(8'hE0);
        frame(8'hF0);
        check_val("prefix_no_event", 32'(bus.empty), 32'h1);
        frame(8'h75);
        check_val("ext_rel_count", 32'(bus.count), 32'h1);
        check_val("ext_rel_data", 32'(bus.rd_data), 32'h375);
        pop();
        frame(8'h75);
        check_val("plain_after_pfx", 32'(bus.rd_data), 32'h075);
        pop();

        // A bad frame must also discard a pending prefix.
        frame(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check_val("badpar_ferr", 32'(bus.frame_err), 32'h1);
        check_val("badpar_empty", 32'(bus.empty), 32'h1);
        frame(8'h1C);
        check_val("good_after_bad_cnt", 32'(bus.count), 32'h1);
        check_val("good_after_bad_data", 32'(bus.rd_data), 32'h01C);
        clear_err();
        check_val("clr_ferr", 32'(bus.frame_err), 32'h0);
        pop();

        send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
        check_val("glitch_count", 32'(bus.count), 32'h1);
        check_val("glitch_data", 32'(bus.rd_data), 32'h02A);
        check_val("glitch_ferr", 32'(bus.frame_err), 32'h0);
        pop();

        frame(8'h15);
        frame(8'h1D);
        frame(8'h24);
        frame(8'h2D);
        frame(8'h2C);
        check_val("ovf_full", 32'(bus.full), 32'h1);
        check_val("ovf_count", 32'(bus.count), 32'h4);
        check_val("ovf_flag", 32'(bus.overflow), 32'h1);
        check_val("ovf_head", 32'(bus.rd_data), 32'h015);
        send_frame(8'h35, 1'b0, 1'b0, 1'b1);
        check_val("full_pushpop_count", 32'(bus.count), 32'h4);
        check_val("full_pushpop_head", 32'(bus.rd_data), 32'h01D);
        pop();
        check_val("order_2", 32'(bus.rd_data), 32'h024);
        pop();
        check_val("order_3", 32'(bus.rd_data), 32'h02D);
        pop();
        check_val("order_4", 32'(bus.rd_data), 32'h035);
        check_val("order_4_count", 32'(bus.count), 32'h1);
        pop();
        check_val("drained_empty", 32'(bus.empty), 32'h1);
        check_val("ovf_still_set", 32'(bus.overflow), 32'h1);
        clear_err();
        check_val("ovf_cleared", 32'(bus.overflow), 32'h0);

        partial = 8'h5A;
`ifdef PS2_RX_TIMEOUT_EN
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(partial[i], 1'b0, 1'b0);
        tick(TIMEOUT_CYCLES + 50);
        check_val("timeout_ferr", 32'(bus.frame_err), 32'h1);
        check_val("timeout_empty", 32'(bus.empty), 32'h1);
        clear_err();
        frame(8'h33);
        check_val("after_timeout_data", 32'(bus.rd_data), 32'h033);
        check_val("after_timeout_ferr", 32'(bus.frame_err), 32'h0);
        pop();
`else
        // Without the timeout an interrupted frame picks up where it stopped.
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(partial[i], 1'b0, 1'b0);
        tick(500);
        for (int i = 4; i < 8; i++) ps2_bit(partial[i], 1'b0, 1'b0);
        ps2_bit(~^partial, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        tick(20);
        check_val("resume_data", 32'(bus.rd_data), 32'h05A);
        check_val("resume_ferr", 32'(bus.frame_err), 32'h0);
        pop();
`endif

        frame(8'h11);
        frame(8'h12);
        frame(8'h13);
        check_val("pre_rst_count", 32'(bus.count), 32'h3);
        ps2_bit(1'b0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        check_val("midrst_empty", 32'(bus.empty), 32'h1);
        check_val("midrst_count", 32'(bus.count), 32'h0);
        rst = 1'b0;
        ps2d = 1'b1;
        tick(10);
        frame(8'h4B);
        check_val("post_rst_count", 32'(bus.count), 32'h1);
        check_val("post_rst_data", 32'(bus.rd_data), 32'h04B);
        check_val("post_rst_ferr", 32'(bus.frame_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
